// File: rtl/alu_result_buffer_if.sv
// Handshake/bus bundle between the ALU result producer, the buffer and the beat consumer.
// master = producer/consumer side, slave = the buffer itself.
interface alu_result_buffer_if #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
);
  logic                     in_valid;
  logic [63:0]              in_result;
  logic [3:0]               in_sel;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_data;
  logic                     out_last;
  logic [3:0]               out_tag;
  logic                     out_zero;
  logic                     out_neg;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic [CW-1:0]            drop_cnt;

  modport master (
    output in_valid, in_result, in_sel, out_ready,
    input  out_valid, out_data, out_last, out_tag, out_zero, out_neg,
           count, full, drop_cnt
  );

  modport slave (
    input  in_valid, in_result, in_sel, out_ready,
    output out_valid, out_data, out_last, out_tag, out_zero, out_neg,
           count, full, drop_cnt
  );
endinterface

// File: rtl/alu_result_buffer.sv
// FIFO of tagged 64-bit ALU results, streamed out as two 32-bit beats (low word first).
// The ALU cannot stall, so writes that find the buffer full are dropped and counted.
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input logic              clk,
  input logic              rst,
  alu_result_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {BEAT_LO = 1'b0, BEAT_HI = 1'b1} beat_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic        zero;
    logic        neg;
    logic [63:0] result;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        wr_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] drop_cnt;
  beat_t         beat;
  logic          valid;
  logic          hs;
  logic          pop;
  logic          accept;

  assign head   = mem[rd_ptr];
  assign valid  = (beat == BEAT_HI) || (count != '0);
  assign hs     = valid && bus.out_ready;
  assign pop    = hs && (beat == BEAT_HI);
  // A completing pop frees a slot in the same cycle, so a full buffer still accepts.
  assign accept = bus.in_valid && ((count < FULL_CNT) || pop);

  always_comb begin
    wr_entry.tag    = bus.in_sel;
    wr_entry.zero   = (bus.in_result == 64'h0);
    wr_entry.neg    = bus.in_result[63];
    wr_entry.result = bus.in_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      beat     <= BEAT_LO;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end else if (bus.in_valid && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      if (hs) beat <= (beat == BEAT_LO) ? BEAT_HI : BEAT_LO;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_data  = (beat == BEAT_HI) ? head.result[63:32] : head.result[31:0];
  assign bus.out_last  = (beat == BEAT_HI);
  assign bus.out_tag   = head.tag;
  assign bus.out_zero  = head.zero;
  assign bus.out_neg   = head.neg;
  assign bus.count     = count;
  assign bus.full      = (count == FULL_CNT);
  assign bus.drop_cnt  = drop_cnt;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: reset, flags, backpressure/drops, full+pop,
// saturation, pointer wrap and asynchronous reset mid-entry.
module tb_alu_result_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  alu_result_buffer_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

  alu_result_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic [3:0] s);
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_sel    = s;
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
  endfunction

  // Present one entry's two beats with out_ready high, checking tag and data.
  task automatic drain_entry(input string tag, input logic [63:0] r, input logic [3:0] s);
    chk({tag, "_v0"},    64'(bus.out_valid), 64'd1);
    chk({tag, "_lo"},    64'(bus.out_data),  64'(r[31:0]));
    chk({tag, "_last0"}, 64'(bus.out_last),  64'd0);
    chk({tag, "_tag0"},  64'(bus.out_tag),   64'(s));
    tick();
    chk({tag, "_hi"},    64'(bus.out_data),  64'(r[63:32]));
    chk({tag, "_last1"}, 64'(bus.out_last),  64'd1);
    chk({tag, "_tag1"},  64'(bus.out_tag),   64'(s));
    tick();
  endtask

  initial begin
    drive(1'b0, 64'h0, 4'h0);
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count),     64'd0);
    chk("rst_full",  64'(bus.full),      64'd0);
    chk("rst_drop",  64'(bus.drop_cnt),  64'd0);
    chk("rst_data",  64'(bus.out_data),  64'd0);
    chk("rst_last",  64'(bus.out_last),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: single write, two beats, then empty
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h0000_0000_1333_ACCC, 4'h0);
    tick();
    drive(1'b0, 64'h0, 4'h0);
    chk("t1_count1", 64'(bus.count), 64'd1);
    chk("t1_valid",  64'(bus.out_valid), 64'd1);
    chk("t1_lo",     64'(bus.out_data), 64'h1333_ACCC);
    chk("t1_last0",  64'(bus.out_last), 64'd0);
    chk("t1_tag",    64'(bus.out_tag), 64'd0);
    tick();
    chk("t1_hi",     64'(bus.out_data), 64'd0);
    chk("t1_last1",  64'(bus.out_last), 64'd1);
    chk("t1_zero",   64'(bus.out_zero), 64'd0);
    chk("t1_neg",    64'(bus.out_neg), 64'd0);
    tick();
    chk("t1_empty",  64'(bus.out_valid), 64'd0);
    chk("t1_count0", 64'(bus.count), 64'd0);

    // 2: zero / negative flags
    drive(1'b1, 64'h0, 4'hF);
    tick();
    drive(1'b1, 64'h8000_0000_0000_0001, 4'h3);
    chk("t2_e1_zero", 64'(bus.out_zero), 64'd1);
    chk("t2_e1_neg",  64'(bus.out_neg),  64'd0);
    chk("t2_e1_tag",  64'(bus.out_tag),  64'hF);
    tick();
    drive(1'b0, 64'h0, 4'h0);
    chk("t2_e1_last", 64'(bus.out_last), 64'd1);
    chk("t2_e1_zhi",  64'(bus.out_zero), 64'd1);
    tick();
    chk("t2_e2_lo",   64'(bus.out_data), 64'h0000_0001);
    chk("t2_e2_zero", 64'(bus.out_zero), 64'd0);
    chk("t2_e2_neg",  64'(bus.out_neg),  64'd1);
    chk("t2_e2_tag",  64'(bus.out_tag),  64'h3);
    tick();
    chk("t2_e2_hi",   64'(bus.out_data), 64'h8000_0000);
    chk("t2_e2_last", 64'(bus.out_last), 64'd1);
    tick();
    chk("t2_empty",   64'(bus.out_valid), 64'd0);

    // 3: backpressure, overflow drops, stable stall, in-order drain
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, pat(i), 4'(i));
      tick();
    end
    drive(1'b0, 64'h0, 4'h0);
    chk("t3_count", 64'(bus.count),    64'd4);
    chk("t3_full",  64'(bus.full),     64'd1);
    chk("t3_drop",  64'(bus.drop_cnt), 64'd2);
    chk("t3_stall_a", 64'(bus.out_data), 64'hB000_0000);
    tick();
    tick();
    chk("t3_stall_b", 64'(bus.out_data), 64'hB000_0000);
    chk("t3_stall_l", 64'(bus.out_last), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drain_entry($sformatf("t3_e%0d", i), pat(i), 4'(i));
    chk("t3_empty", 64'(bus.out_valid), 64'd0);

    // 4: full buffer accepts a write in the cycle of a completing pop
    bus.out_ready = 1'b0;
    for (int i = 4; i < 8; i++) begin
      drive(1'b1, pat(i), 4'(i));
      tick();
    end
    drive(1'b0, 64'h0, 4'h0);
    chk("t4_full", 64'(bus.full), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("t4_beat1", 64'(bus.out_last), 64'd1);
    drive(1'b1, pat(8), 4'd8);
    tick();
    drive(1'b0, 64'h0, 4'h0);
    chk("t4_count", 64'(bus.count),    64'd4);
    chk("t4_drop",  64'(bus.drop_cnt), 64'd2);
    for (int i = 5; i < 9; i++) drain_entry($sformatf("t4_e%0d", i), pat(i), 4'(i));
    chk("t4_empty", 64'(bus.count), 64'd0);

    // 5: drop counter saturation, then wrap rounds
    bus.out_ready = 1'b0;
    for (int i = 0; i < 304; i++) begin
      drive(1'b1, pat(20), 4'hE);
      tick();
    end
    drive(1'b0, 64'h0, 4'h0);
    chk("t5_sat",  64'(bus.drop_cnt), 64'hFF);
    chk("t5_full", 64'(bus.full),     64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tick();
    tick();
    tick();
    tick();
    chk("t5_drained", 64'(bus.count), 64'd0);
    for (int r = 0; r < 3; r++) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, pat(40 + 4*r + i), 4'(4*r + i));
        tick();
      end
      drive(1'b0, 64'h0, 4'h0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++)
        drain_entry($sformatf("t5_r%0d_e%0d", r, i), pat(40 + 4*r + i), 4'(4*r + i));
    end
    chk("t5_sat_hold", 64'(bus.drop_cnt), 64'hFF);

    // 6: asynchronous reset between beat 0 and beat 1
    drive(1'b1, pat(60), 4'hA);
    tick();
    drive(1'b0, 64'h0, 4'h0);
    tick();
    bus.out_ready = 1'b0;
    chk("t6_mid", 64'(bus.out_last), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_count", 64'(bus.count),     64'd0);
    chk("t6_drop",  64'(bus.drop_cnt),  64'd0);
    chk("t6_last",  64'(bus.out_last),  64'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    tick();
    drive(1'b1, pat(61), 4'hB);
    tick();
    drive(1'b0, 64'h0, 4'h0);
    bus.out_ready = 1'b1;
    drain_entry("t6_new", pat(61), 4'hB);
    chk("t6_end", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream consumer of the registered 32-bit ALU's 64-bit result bus.
- Captures each valid result with its 4-bit opcode tag and derived flags into a small FIFO.
- Streams each entry onto a 32-bit valid/ready bus as two beats: low word first, then high word.
- Absorbs consumer backpressure. The ALU itself has no stall input, so results arriving while the buffer is full are dropped and counted.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- CW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_result/in_sel hold a new ALU result this cycle.
- in_result  input  64  ALU result word.
- in_sel  input  4  opcode that produced in_result (tag).
- out_valid  output  1  a beat is presented.
- out_ready  input  1  consumer accepts beat when out_valid && out_ready.
- out_data  output  32  beat data: head[31:0] on beat 0, head[63:32] on beat 1.
- out_last  output  1  high on beat 1 (second beat of an entry).
- out_tag  output  4  opcode tag of head entry, same on both beats.
- out_zero  output  1  head result == 64'h0.
- out_neg  output  1  head result bit 63.
- count  output  clog2(DEPTH)+1  entries currently stored.
- full  output  1  count == DEPTH.
- drop_cnt  output  CW  results dropped; saturates at all-ones.

Behaviour:
- Reset (async assert, sync-release safe):
  - wr_ptr, rd_ptr, count, beat, drop_cnt = 0.
  - out_valid = 0, out_last = 0, full = 0.
  - Storage cleared, so out_data/out_tag/out_zero/out_neg read 0.
- Entry format: {tag[3:0], zero, neg, result[63:0]}. zero and neg are computed at write time from in_result and stored.
- pop = out_valid && out_ready && beat == 1.
- Write acceptance: accept = in_valid && (count < DEPTH || pop).
  - A full buffer with a completing pop in the same cycle accepts the write.
  - Accepted entry is stored at wr_ptr on the rising edge; wr_ptr increments, wrapping modulo DEPTH.
- Drop: in_valid && !accept increments drop_cnt by 1, holding at 2^CW-1. Nothing else changes.
- Count update: count += accept - pop. Simultaneous accept and pop leaves count unchanged. full and empty are derived from the registered count.
- Latency: a result written at edge k gives out_valid = 1 in the cycle after edge k, with beat 0 presented. There is no same-cycle bypass.
- Output beat FSM, state held in the beat register:
  - BEAT_LO (beat = 0): out_valid = (count != 0). Handshake moves to BEAT_HI.
  - BEAT_HI (beat = 1): out_valid = 1, out_last = 1. Handshake pops the entry (rd_ptr increments, wrapping) and returns to BEAT_LO.
  - Without a handshake the state holds, and out_data, out_tag, out_last and the flags stay stable while out_valid && !out_ready.
- Back-to-back: with out_ready held high, N entries drain in exactly 2N cycles with no bubble between entries.
- Empty: out_valid = 0 and beat = 0. out_ready is ignored.
- Reset mid-transfer: the partially sent entry and all stored entries are discarded. No resumption of the high beat after release.
- Pointer wrap: full DEPTH fill/drain cycles repeated with wrapping pointers must preserve order.

Test Plan:
1. Reset then single write: in_result=64'h0000_0000_1333_ACCC, in_sel=0, out_ready=1 -> next cycle out_data=32'h1333_ACCC, out_last=0, out_tag=0; following cycle out_data=0, out_last=1, out_zero=0, out_neg=0; then out_valid=0, count=0.
2. Flags: write 64'h0 tag 4'hF, then 64'h8000_0000_0000_0001 tag 4'h3 -> entry 1 has out_zero=1, out_neg=0; entry 2 has out_zero=0, out_neg=1, beat 1 data 32'h8000_0000.
3. Backpressure/overflow: out_ready=0, write 6 consecutive results with DEPTH=4 -> count=4, full=1, drop_cnt=2. Then raise out_ready -> 8 beats emerge in write order over 8 cycles, out_data stable during stall.
4. Full plus simultaneous pop: fill to 4, hold out_ready=1 and present in_valid on the cycle of the first beat-1 handshake -> write accepted, drop_cnt unchanged, count stays 4.
5. Saturation and wrap: with out_ready=0 and buffer full, drive 300 writes -> drop_cnt=8'hFF. Then run 3 full fill/drain rounds of distinct tags 0..11 -> tags emerge 0..11 in order.
6. Async reset mid-stream: assert rst between beat 0 and beat 1 of an entry, not aligned to clk -> out_valid, count and drop_cnt drop to 0 immediately. After release, the next write emits its own beat 0 first.
